// File: rtl/scm_mp.sv
// Multi-read-port standard-cell memory: one byte-masked write port, NUM_RD registered read ports,
// zero-init sequencer after reset. Define SCM_MP_BYPASS_EN for write-first same-row read behaviour.
module scm_mp #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_RD     = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         SE,
    input  logic                         WE,
    input  logic [ADDR_WIDTH-1:0]        WADDR,
    input  logic [DATA_WIDTH/8-1:0]      WBE,
    input  logic [DATA_WIDTH-1:0]        DIN,
    input  logic [NUM_RD-1:0]            RE,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] RADDR,
    output logic [NUM_RD*DATA_WIDTH-1:0] DOUT,
    output logic [NUM_RD-1:0]            VALID,
    output logic                         BUSY
);

    localparam int DEPTH  = 2**ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH/8;

    localparam logic ST_INIT  = 1'b0;
    localparam logic ST_READY = 1'b1;

    logic                         r_state;
    logic [ADDR_WIDTH-1:0]        r_cnt;
    logic [DATA_WIDTH-1:0]        r_mem [DEPTH];
    logic [NUM_RD*DATA_WIDTH-1:0] r_dout;
    logic [NUM_RD-1:0]            r_valid;

    logic                         w_active;
    logic                         w_ready;
    logic                         w_wr_en;
    logic [DATA_WIDTH-1:0]        w_old;
    logic [DATA_WIDTH-1:0]        w_merged;
    logic [NUM_RD*DATA_WIDTH-1:0] w_rd_data;

    assign w_active = !RST && !SE;
    assign w_ready  = (r_state == ST_READY);
    assign w_wr_en  = w_active && w_ready && WE;
    assign w_old    = r_mem[WADDR];

    always_comb begin
        w_merged = w_old;
        for (int unsigned b = 0; b < NBYTES; b++) begin
            if (WBE[b]) begin
                w_merged[8*b +: 8] = DIN[8*b +: 8];
            end
        end
    end

    // The counter wraps to zero on the last row, so it is already clean for the next reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else if (!SE && r_state == ST_INIT) begin
            r_cnt <= r_cnt + 1'b1;
            if (&r_cnt) begin
                r_state <= ST_READY;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_active) begin
            if (!w_ready) begin
                r_mem[r_cnt] <= '0;
            end else if (WE) begin
                r_mem[WADDR] <= w_merged;
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
`ifdef SCM_MP_BYPASS_EN
            if (w_wr_en && WADDR == RADDR[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                w_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = w_merged;
            end else begin
                w_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[RADDR[i*ADDR_WIDTH +: ADDR_WIDTH]];
            end
`else
            w_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[RADDR[i*ADDR_WIDTH +: ADDR_WIDTH]];
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_dout  <= '0;
            r_valid <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_RD; i++) begin
                if (!SE && w_ready && RE[i]) begin
                    r_dout[i*DATA_WIDTH +: DATA_WIDTH] <= w_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
                    r_valid[i] <= 1'b1;
                end else begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign DOUT  = r_dout;
    assign VALID = r_valid;
    assign BUSY  = (r_state == ST_INIT);

endmodule

// File: tb/tb_scm_mp.sv
// Scoreboard bench for scm_mp: reads push expected data, a negedge monitor pops on VALID.
module tb_scm_mp;

    localparam int AW    = 6;
    localparam int DW    = 64;
    localparam int NR    = 2;
    localparam int DEPTH = 64;

    logic           CLK = 1'b0;
    logic           RST;
    logic           SE;
    logic           WE;
    logic [AW-1:0]  WADDR;
    logic [7:0]     WBE;
    logic [DW-1:0]  DIN;
    logic [NR-1:0]  RE;
    logic [NR*AW-1:0] RADDR;
    logic [NR*DW-1:0] DOUT;
    logic [NR-1:0]  VALID;
    logic           BUSY;

    scm_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR)) dut (
        .CLK(CLK), .RST(RST), .SE(SE), .WE(WE), .WADDR(WADDR), .WBE(WBE), .DIN(DIN),
        .RE(RE), .RADDR(RADDR), .DOUT(DOUT), .VALID(VALID), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          port;
        int          cyc;
        logic [63:0] data;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [63:0] model [DEPTH];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: each VALID pops the oldest expectation for that port.
    always @(negedge CLK) begin
        int idx;
        for (int p = 0; p < NR; p++) begin
            idx = -1;
            for (int k = 0; k < sbq.size(); k++) begin
                if (sbq[k].port == p) begin
                    idx = k;
                    break;
                end
            end
            if (idx >= 0 && sbq[idx].cyc + 1 < cyc) begin
                checks++;
                errors++;
                $display("FAIL rd_missing: port %0d got no VALID, required one at cycle %0d", p, sbq[idx].cyc + 1);
                sbq.delete(idx);
                idx = -1;
            end
            if (VALID[p]) begin
                if (idx < 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: port %0d got VALID=1 required 0", p);
                end else begin
                    check64("rd_latency", 64'(cyc), 64'(sbq[idx].cyc + 1));
                    check64("rd_data", DOUT[p*DW +: DW], sbq[idx].data);
                    sbq.delete(idx);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        WE = 1'b0; WADDR = '0; WBE = '0; DIN = '0; RE = '0; RADDR = '0;
    endtask

    task automatic push(input int port, input logic [63:0] d);
        exp_t e;
        e.port = port;
        e.cyc  = cyc;
        e.data = d;
        sbq.push_back(e);
    endtask

    task automatic wr(input logic [5:0] a, input logic [63:0] d, input logic [7:0] be);
        WE = 1'b1; WADDR = a; DIN = d; WBE = be;
        tick();
        WE = 1'b0; WBE = '0;
        for (int b = 0; b < 8; b++) if (be[b]) model[a][8*b +: 8] = d[8*b +: 8];
    endtask

    // Read both ports with model-derived expectations.
    task automatic rd(input logic [5:0] a0, input logic [5:0] a1);
        RE = 2'b11; RADDR = {a1, a0};
        push(0, model[a0]);
        push(1, model[a1]);
        tick();
        RE = '0;
    endtask

    // Read both ports of one row against a hand-computed constant.
    task automatic rd_hand(input logic [5:0] a, input logic [63:0] exp);
        RE = 2'b11; RADDR = {a, a};
        push(0, exp);
        push(1, exp);
        tick();
        RE = '0;
    endtask

    task automatic count_busy(input string nm, input int exp_edges);
        int n = 0;
        while (BUSY && n < 300) begin
            tick();
            n++;
        end
        check64(nm, 64'(n), 64'(exp_edges));
        for (int r = 0; r < DEPTH; r++) model[r] = '0;
    endtask

    task automatic check_reset_outputs(input string nm);
        check64({nm, "_dout0"}, DOUT[63:0], 64'h0);
        check64({nm, "_dout1"}, DOUT[127:64], 64'h0);
        check64({nm, "_valid"}, 64'(VALID), 64'h0);
        check64({nm, "_busy"}, 64'(BUSY), 64'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] rdw_exp;
        int n;
        idle();
        SE = 1'b0;
        RST = 1'b1;

        // 1. reset and init
        tick();
        tick();
        check_reset_outputs("reset");
        RST = 1'b0;
        count_busy("init_edges", 64);
        rd_hand(6'd0, 64'h0);
        rd_hand(6'd31, 64'h0);
        rd_hand(6'd63, 64'h0);

        // 2. full sweep, port 1 reversed
        for (int i = 0; i < DEPTH; i++) wr(6'(i), {$urandom, $urandom}, 8'hFF);
        for (int i = 0; i < DEPTH; i++) rd(6'(i), 6'(DEPTH - 1 - i));

        // 3. byte mask, plus WBE=0 no-op
        wr(6'd5, 64'h1111_2222_3333_4444, 8'hFF);
        wr(6'd5, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F);
        rd_hand(6'd5, 64'h1111_2222_CCCC_DDDD);
        wr(6'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        rd_hand(6'd5, 64'h1111_2222_CCCC_DDDD);

        // 4. read-during-write on the same row
        wr(6'd9, 64'h0, 8'hFF);
`ifdef SCM_MP_BYPASS_EN
        rdw_exp = 64'hFF;
`else
        rdw_exp = 64'h0;
`endif
        WE = 1'b1; WADDR = 6'd9; DIN = 64'hFF; WBE = 8'hFF;
        RE = 2'b01; RADDR = {6'd0, 6'd9};
        push(0, rdw_exp);
        tick();
        idle();
        model[9] = 64'hFF;
        rd_hand(6'd9, 64'hFF);

        // 5. sleep in READY
        wr(6'd3, 64'h1234, 8'hFF);
        RE = 2'b01; RADDR = {6'd0, 6'd3};
        push(0, 64'h1234);
        tick();
        RE = '0;
        SE = 1'b1;
        for (int k = 0; k < 10; k++) begin
            WE = k[0]; WADDR = 6'(k); DIN = '1; WBE = 8'hFF;
            RE = k[0] ? 2'b11 : 2'b00; RADDR = 12'($urandom);
            tick();
            check64("sleep_dout0", DOUT[63:0], 64'h1234);
            check64("sleep_valid", 64'(VALID), 64'h0);
        end
        SE = 1'b0;
        idle();
        for (int k = 0; k < 10; k++) rd(6'(k), 6'(k + 10));

        // 5b. sleep during INIT stretches it by the sleep length
        RST = 1'b1;
        tick();
        check_reset_outputs("rst_sleep");
        RST = 1'b0;
        n = 0;
        while (BUSY && n < 300) begin
            SE = (n >= 5 && n < 15);
            tick();
            n++;
        end
        SE = 1'b0;
        check64("init_sleep_edges", 64'(n), 64'd74);
        for (int r = 0; r < DEPTH; r++) model[r] = '0;

        // 6. reset mid-INIT at cnt=20, then in READY after writes
        for (int i = 0; i < DEPTH; i++) wr(6'(i), {$urandom, $urandom}, 8'hFF);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        check64("mid_init_busy", 64'(BUSY), 64'h1);
        RST = 1'b1;
        tick();
        check_reset_outputs("rst_mid_init");
        RST = 1'b0;
        count_busy("init_edges_mid", 64);
        for (int i = 0; i < DEPTH; i++) rd(6'(i), 6'(DEPTH - 1 - i));

        wr(6'd7, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF);
        wr(6'd40, 64'h0123_4567_89AB_CDEF, 8'hFF);
        rd(6'd7, 6'd40);
        RST = 1'b1;
        tick();
        check_reset_outputs("rst_ready");
        RST = 1'b0;
        count_busy("init_edges_ready", 64);
        for (int i = 0; i < DEPTH; i++) rd(6'(i), 6'(DEPTH - 1 - i));

        tick();
        tick();
        check64("sb_empty", 64'(sbq.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
